// File: rtl/fifo_byte_serializer_pkg.sv
// Shared constants and byte-lane helper for the word-to-byte serializer.
package fifo_byte_serializer_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_BYTES      = DEF_WORD_WIDTH / BYTE_W;

    function automatic int byte_index(
        input int idx,
        input bit msb_first,
        input int nbytes = DEF_BYTES
    );
        return msb_first ? (nbytes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/fifo_byte_serializer.sv
// Drains words from the upstream FIFO and emits them one byte per handshake,
// with a one-word holding register so consecutive words stream without bubbles.
module fifo_byte_serializer
    import fifo_byte_serializer_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  fifo_empty,
    input  logic [WORD_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_deq,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int BYTES = WORD_WIDTH / BYTE_W;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    if (WORD_WIDTH % BYTE_W != 0 || BYTES < 1) begin : g_bad_width
        $error("WORD_WIDTH must be a positive multiple of 8");
    end

    logic                  pending;
    logic                  cur_valid;
    logic                  hold_valid;
    logic [IDX_W-1:0]      cur_idx;
    logic [WORD_WIDTH-1:0] cur_word;
    logic [WORD_WIDTH-1:0] hold_word;

    logic [BYTES-1:0][BYTE_W-1:0] cur_bytes;
    logic [IDX_W-1:0]             sel_idx;

    logic is_last;
    logic xfer;
    logic last_xfer;
    logic capture;
    logic load_cur;
    logic load_hold;
    logic refill;

    assign is_last   = cur_valid && (cur_idx == LAST_IDX);
    assign xfer      = cur_valid && m_ready;
    assign last_xfer = xfer && is_last;
    assign capture   = pending && fifo_valid;
    assign refill    = last_xfer && hold_valid;

    // Arriving word goes straight to the shifter only if it is free this cycle.
    assign load_cur  = capture && (!cur_valid || (last_xfer && !hold_valid));
    assign load_hold = capture && !load_cur;

    assign fifo_deq = !rst_in && !fifo_empty && !pending && !hold_valid;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending    <= 1'b0;
            cur_valid  <= 1'b0;
            hold_valid <= 1'b0;
            cur_idx    <= '0;
            cur_word   <= '0;
            hold_word  <= '0;
        end else begin
            if (fifo_deq) begin
                pending <= 1'b1;
            end else if (capture) begin
                pending <= 1'b0;
            end

            if (refill) begin
                cur_word <= hold_word;
                cur_idx  <= '0;
            end else if (load_cur) begin
                cur_word  <= fifo_data;
                cur_idx   <= '0;
                cur_valid <= 1'b1;
            end else if (last_xfer) begin
                cur_valid <= 1'b0;
            end else if (xfer) begin
                cur_idx <= cur_idx + 1'b1;
            end

            if (load_hold) begin
                hold_word  <= fifo_data;
                hold_valid <= 1'b1;
            end else if (refill) begin
                hold_valid <= 1'b0;
            end
        end
    end

    assign cur_bytes = cur_word;

    always_comb begin
        sel_idx = IDX_W'(byte_index(int'(cur_idx), MSB_FIRST, BYTES));
        m_data  = cur_bytes[sel_idx];
    end

    assign m_valid = cur_valid;
    assign m_last  = is_last;
    assign busy    = pending || cur_valid || hold_valid;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Randomized bench: FIFO model feeds an LSB-first and an MSB-first serializer,
// byte streams are scored against per-word expected byte queues.
module tb_fifo_byte_serializer;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_in     = 1'b1;
    logic        m_ready    = 1'b0;
    logic        stray      = 1'b0;
    logic        fifo_flush = 1'b0;
    logic        fifo_valid = 1'b0;
    logic [31:0] fifo_data  = '0;
    logic        fifo_empty;

    logic       fifo_deq0, m_valid0, m_last0, busy0;
    logic       fifo_deq1, m_valid1, m_last1, busy1;
    logic [7:0] m_data0, m_data1;

    int push_cnt = 0;
    int pop_cnt  = 0;
    logic [31:0] wq[$];
    logic [8:0]  exp0[$];
    logic [8:0]  exp1[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int deq_cnt  = 0;
    int deq_viol = 0;
    int deq_diff = 0;

    fifo_byte_serializer #(.WORD_WIDTH(32), .MSB_FIRST(1'b0)) dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_deq(fifo_deq0),
        .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0),
        .m_ready(m_ready), .busy(busy0)
    );

    fifo_byte_serializer #(.WORD_WIDTH(32), .MSB_FIRST(1'b1)) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_deq(fifo_deq1),
        .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1),
        .m_ready(m_ready), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // FIFO model: registered data/valid pulse one cycle after an accepted deq.
    assign fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk_in) begin
        if (fifo_flush) begin
            pop_cnt    <= push_cnt;
            fifo_valid <= 1'b0;
        end else if (fifo_deq0 && !fifo_empty) begin
            fifo_data  <= wq[pop_cnt];
            fifo_valid <= 1'b1;
            pop_cnt    <= pop_cnt + 1;
        end else if (stray) begin
            fifo_data  <= 32'hDEADBEEF;
            fifo_valid <= 1'b1;
        end else begin
            fifo_valid <= 1'b0;
        end
    end

    // Sink monitor: a byte is taken on the next edge when valid && ready now.
    always @(negedge clk_in) begin
        logic [8:0] e;
        if (!rst_in) begin
            if (fifo_deq0) deq_cnt++;
            if (fifo_deq0 && fifo_valid) deq_viol++;
            if (fifo_deq0 !== fifo_deq1) deq_diff++;
            if (m_valid0 && m_ready) begin
                if (exp0.size() == 0) begin
                    chk("unexpected byte lsb", 32'(m_valid0), 32'd0);
                end else begin
                    e = exp0.pop_front();
                    chk("byte lsb", {23'd0, m_last0, m_data0}, {23'd0, e});
                end
            end
            if (m_valid1 && m_ready) begin
                if (exp1.size() == 0) begin
                    chk("unexpected byte msb", 32'(m_valid1), 32'd0);
                end else begin
                    e = exp1.pop_front();
                    chk("byte msb", {23'd0, m_last1, m_data1}, {23'd0, e});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        logic [7:0] lo;
        logic [7:0] hi;
        wq.push_back(w);
        push_cnt++;
        for (int k = 0; k < 4; k++) begin
            lo = 8'((w >> (8 * k)) & 32'hFF);
            hi = 8'((w >> (8 * (3 - k))) & 32'hFF);
            exp0.push_back({k == 3, lo});
            exp1.push_back({k == 3, hi});
        end
    endtask

    task automatic wait_drain(input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            if (exp0.size() == 0 && exp1.size() == 0 && !busy0 && !busy1
                && fifo_empty)
                done = 1'b1;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int hold_err;
        int pushed;
        bit seen;

        repeat (3) tick();
        chk("deq in reset", 32'(fifo_deq0), 32'd0);
        rst_in = 1'b0;
        #1;
        chk("reset m_valid", 32'(m_valid0), 32'd0);
        chk("reset m_data", 32'(m_data0), 32'h00);
        chk("reset m_last", 32'(m_last0), 32'd0);
        chk("reset busy", 32'(busy0), 32'd0);
        chk("reset deq", 32'(fifo_deq0), 32'd0);
        chk("reset m_data msb", 32'(m_data1), 32'h00);

        // Single word, latency
        m_ready = 1'b1;
        push(32'hA1B2C3D4);
        #1;
        chk("lat deq n", 32'(fifo_deq0), 32'd1);
        tick();
        chk("lat valid n+1", 32'(m_valid0), 32'd0);
        chk("lat deq n+1", 32'(fifo_deq0), 32'd0);
        tick();
        chk("lat valid n+2", 32'(m_valid0), 32'd1);
        chk("first byte lsb", 32'(m_data0), 32'hD4);
        chk("first byte msb", 32'(m_data1), 32'hA1);
        wait_drain(50, "drain single");

        // Streaming, no bubbles
        for (int i = 1; i <= 16; i++) push(32'(i));
        gaps = 0;
        seen = 1'b0;
        for (int c = 0; c < 300 && exp0.size() > 0; c++) begin
            tick();
            if (m_valid0) seen = 1'b1;
            else if (seen && exp0.size() > 0) gaps++;
        end
        chk("stream gaps", 32'(gaps), 32'd0);
        wait_drain(50, "drain stream");

        // Back-pressure
        m_ready = 1'b0;
        deq_cnt = 0;
        push(32'h0A0B0C0D);
        push(32'h1A2B3C4D);
        push(32'h5E6F7081);
        repeat (2) tick();
        hold_err = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!m_valid0 || m_data0 !== exp0[0][7:0] || m_last0) hold_err++;
        end
        chk("bp hold first byte", 32'(hold_err), 32'd0);
        chk("bp deq pulses", 32'(deq_cnt), 32'd2);
        chk("bp word left in fifo", 32'(fifo_empty), 32'd0);
        chk("bp busy", 32'(busy0), 32'd1);
        m_ready = 1'b1;
        wait_drain(60, "drain bp");

        // Random ready, random arrival
        pushed = 0;
        for (int c = 0; c < 6000 && (pushed < 100 || exp0.size() > 0); c++) begin
            m_ready = 1'($urandom % 2);
            if (pushed < 100 && ($urandom % 3) == 0) begin
                push($urandom);
                pushed++;
            end
            tick();
        end
        m_ready = 1'b1;
        wait_drain(100, "drain random");

        // Stray valid while idle
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        tick();
        chk("stray m_valid", 32'(m_valid0), 32'd0);
        chk("stray busy", 32'(busy0), 32'd0);

        // Reset mid-word
        m_ready = 1'b1;
        push(32'h11223344);
        for (int c = 0; c < 50 && exp0.size() > 2; c++) tick();
        chk("mid-word before reset", 32'(m_valid0), 32'd1);
        rst_in     = 1'b1;
        fifo_flush = 1'b1;
        exp0.delete();
        exp1.delete();
        tick();
        chk("after reset m_valid", 32'(m_valid0), 32'd0);
        chk("after reset busy", 32'(busy0), 32'd0);
        chk("after reset m_data", 32'(m_data0), 32'h00);
        rst_in     = 1'b0;
        fifo_flush = 1'b0;
        repeat (5) tick();
        chk("no old bytes", 32'(m_valid0), 32'd0);
        push(32'h55667788);
        wait_drain(50, "drain restart");

        chk("deq while pending", 32'(deq_viol), 32'd0);
        chk("deq lsb/msb agree", 32'(deq_diff), 32'd0);
        chk("leftover bytes", 32'(exp0.size() + exp1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
